// File: rtl/conv_encoder.sv
// Rate-1/r convolutional encoder feeding the Viterbi decoder.
// It starts from the all-zero state and appends no tail bits.
module conv_encoder #(
  parameter int r      = 2,
  parameter int K      = 3,
  parameter int lenin  = 10,
  parameter int lenout = 5,
  parameter logic [r*K-1:0] GEN = 6'b111_101
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [lenout-1:0] msgin,
  output logic              busy,
  output logic              sym_valid,
  output logic [r-1:0]      sym_out,
  output logic [lenin-1:0]  codeout,
  output logic              finish
);

  localparam int CW = $clog2(lenout + 1);

  typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;

  state_t            state, state_next;
  logic [lenout-1:0] msg;
  logic [K-2:0]      hist;
  logic [CW-1:0]     cnt;
  logic [K-1:0]      window;
  logic [r-1:0]      sym_next;
  logic [lenin-1:0]  sym_placed;
  logic              accept;
  logic              last;

  // The message latch shifts left, so its MSB is always the next bit to encode.
  always_comb begin
    sym_next = '0;
    accept   = start && (state != ENC);
    last     = (state == ENC) && (cnt == CW'(lenout - 1));
    window   = {msg[lenout-1], hist};
    for (int j = 0; j < r; j++) begin
      sym_next[r-1-j] = ^(window & GEN[(r-1-j)*K +: K]);
    end
    sym_placed = {sym_next, {(lenin-r){1'b0}}} >> (int'(cnt) * r);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ENC;
      ENC:     if (last)  state_next = DONE;
      DONE:    if (start) state_next = ENC;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg       <= '0;
      hist      <= '0;
      cnt       <= '0;
      codeout   <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      finish    <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      if (accept) begin
        msg     <= msgin;
        hist    <= '0;
        cnt     <= '0;
        codeout <= '0;
        finish  <= 1'b0;
      end else if (state == ENC) begin
        sym_out   <= sym_next;
        sym_valid <= 1'b1;
        codeout   <= codeout | sym_placed;
        msg       <= {msg[lenout-2:0], 1'b0};
        hist[K-2] <= msg[lenout-1];
        for (int i = 0; i < K - 2; i++) begin
          hist[i] <= hist[i+1];
        end
        cnt <= cnt + 1'b1;
        if (last) finish <= 1'b1;
      end
    end
  end

  assign busy = (state == ENC);

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
- Rate-1/r convolutional encoder; it is the transmit-side counterpart of the team's Viterbi decoder.
- Encodes a lenout-bit message into a lenin-bit code word. The code word bit order matches what the decoder consumes: the first-encoded symbol sits in the MSB pair.
- Also streams each r-bit symbol with a valid strobe, so a channel model or serializer can tap it.
- Start state is all-zero, which matches the decoder's initial state 0. No tail bits are appended.

Parameters:
- r, 2: parity bits per message bit (symbol width).
- K, 3: constraint length (current bit plus K-1 history bits).
- lenin, 10: code word length; must equal r*lenout.
- lenout, 5: message length.
- GEN, 6'b111_101: packed generators, r*K bits. Generator j is GEN[(r-1-j)*K +: K]. The MSB of each generator taps the current input bit; the LSB taps the oldest history bit.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request to encode msgin; sampled only when not busy.
- msgin  input  lenout  message; msgin[lenout-1] is encoded first.
- busy  output  1  high while encoding.
- sym_valid  output  1  one-cycle strobe; sym_out holds a new symbol.
- sym_out  output  r  current symbol; parity of generator 0 is in the MSB.
- codeout  output  lenin  assembled code word.
- finish  output  1  level flag: code word complete.

Behaviour:
- Reset (async, rst=0): state=IDLE; busy=0, sym_valid=0, sym_out=0, codeout=0, finish=0; shift register, bit counter and message latch cleared. Reset mid-encoding aborts immediately. There is no partial finish.
- States: IDLE, ENC, DONE.
- IDLE or DONE with start=1 at edge E0:
  - latch msgin;
  - clear the K-1-bit history to 0, bit count cnt=0, codeout=0, finish=0;
  - busy=1; go to ENC.
- ENC, one message bit per cycle:
  - At edge En (n=1..lenout), u = msg[lenout-n].
  - Window w = {u, h[K-2:0]}, where h[K-2] is the most recent previous bit.
  - p_j = XOR of (w & G_j).
  - sym_out = {p_0..p_{r-1}}, sym_valid=1.
  - codeout[lenin-1-(n-1)*r -: r] = sym_out.
  - h shifts right with u entering at h[K-2]; cnt increments.
- At edge E_lenout the last symbol is written, finish=1 and busy=0 on the same edge, then state goes to DONE.
- Latency: first symbol 1 cycle after start is sampled; finish lenout cycles after start is sampled.
- sym_valid is high exactly lenout consecutive cycles per message and deasserts on the edge after E_lenout.
- DONE: codeout and finish hold until the next accepted start or reset.
- start while busy: ignored; msgin changes while busy are ignored.
- start held high continuously: a new encoding begins on the first edge in DONE. finish is high for exactly that one cycle.
- codeout bits not yet written during ENC read 0.
- All parity arithmetic is XOR modulo 2. No counters wrap, since cnt width is at least clog2(lenout+1).

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 → all outputs 0, busy=0; after release, start=1, msgin=5'b10110 → busy=1 the cycle after sampling.
- Basic encode: msgin=5'b10110, default GEN → sym_out sequence 11,10,00,01,01 on 5 consecutive sym_valid cycles; codeout=10'b1110000101 (0x385); finish=1 five cycles after start was sampled.
- Patterns: msgin=5'b00000 → codeout=0x000; msgin=5'b10000 → 0x3B0; msgin=5'b11111 → 0x36A (symbols 11,01,10,10,10).
- Ignored start: pulse start with a different msgin during ENC → codeout unchanged (0x385 for 5'b10110); exactly 5 sym_valid pulses.
- Back-to-back: keep start=1 and change msgin to 5'b10000 in DONE → a new run begins, codeout clears to 0, then ends at 0x3B0. History is cleared, so the result is unaffected by the previous message.
- Reset mid-run: assert rst=0 after 2 symbols → outputs return to 0 asynchronously; a subsequent start of 5'b11111 gives 0x36A.
